timer0_ctrl: RTL and testbench
==============================

Name: timer0_ctrl

Overview:
- Controller that sequences an 8-bit timer/counter datapath for the ATMega32A emulator, modelled on Timer/Counter0.
- Generates prescaled count enables from clock50, holds TCNT0/OCR0/TCCR0/TIFR/TIMSK, and runs Normal or CTC count modes.
- Produces overflow and compare flags, interrupt requests and the OC0 pin output.
- Sits between the CPU register bus and the GPIO/interrupt logic.

Parameters:
- PRESC_WIDTH, 10, width of the free-running prescaler; must be at least 10 so /1024 is reachable.
- TCNT_WIDTH, 8, timer count width; only 8 is supported and the bench must check it.

Ports:
- clock50 input 1: system clock; all state changes on its rising edge.
- MR input 1: master reset, asynchronous, active-high.
- wr_en input 1: register write strobe, one cycle per write.
- addr input 3: register select for reads and writes. 0=TCCR0, 1=TCNT0, 2=OCR0, 3=TIFR, 4=TIMSK; 5-7 reserved.
- wr_data input 8: write data.
- rd_data output 8: combinational read of the register at addr. Reserved addresses read 0x00; FOC0 reads 0.
- tcnt output 8: current count value.
- irq_ovf output 1: TOV0 & TOIE0.
- irq_cmp output 1: OCF0 & OCIE0.
- oc0 output 1: compare output pin.

Behaviour:
- Reset (MR=1, asynchronous): all registers 0x00, prescaler 0, compare block 0, oc0=0, state STOP. Outputs are therefore tcnt=0, flags 0, irq_* 0, oc0=0.
- TCCR0 bit fields:
  - [7] FOC0: write-only strobe.
  - [5:4] COM0: 00 disconnected, 01 toggle, 10 clear, 11 set.
  - [3] CTC mode.
  - [2:0] CS0: 000 stop, 001 /1, 010 /8, 011 /64, 100 /256, 101 /1024. 110 and 111 are treated as stop (external clock unsupported).
- TIFR bits: [1] OCF0, [0] TOV0. TIMSK bits: [1] OCIE0, [0] TOIE0.
- FSM STOP: CS decodes to stop. Prescaler held at 0, no ticks. Go to RUN on a valid CS write.
- FSM RUN: prescaler increments every clock. Go to STOP when CS decodes to stop.
- Tick generation:
  - /1: tick every clock.
  - /N: tick when prescaler[log2N-1:0] is all ones, i.e. every N clocks.
  - The first tick falls on the Nth rising edge after the CS write edge. A CS change in RUN does not clear the prescaler.
- On a tick, with m = (TCNT==OCR) and compare not blocked:
  - If m: set OCF0 and apply the COM0 action to oc0. In CTC mode load TCNT=0; in Normal mode increment TCNT.
  - If not m: increment TCNT, wrapping 0xFF to 0x00.
  - TOV0 is set only when TCNT goes 0xFF to 0x00. In CTC mode with OCR=0xFF, TOV0 and OCF0 are both set.
  - The compare block clears on every tick.
- CTC period is OCR+1 ticks. OCR=0 in CTC mode gives a match on every tick.
- TCNT write:
  - Loads wr_data and sets the compare block, so the next tick cannot match.
  - If a tick occurs in the same cycle, the write wins: no increment and no flags from that tick.
- OCR write takes effect immediately; there is no double buffering.
- TIFR write: writing 1 clears the corresponding flag; writing 0 has no effect. A hardware flag set in the same cycle wins over the clear.
- FOC0=1 in a TCCR0 write:
  - Applies the COM0 action to oc0 on that edge, without setting OCF0 or clearing TCNT.
  - The other TCCR0 fields in the same write are still stored.
- COM0=00: oc0 holds its last value.
- Latency: flags and irq_* are registered and visible the clock after the tick edge. rd_data has zero latency.

Decomposition:
- Shared header timer0_pkg holds:
  - register address constants;
  - CS0 encodings;
  - COM0 encodings;
  - TCCR0, TIFR and TIMSK bit positions;
  - FSM state encodings.
- One sub-module, timer_prescaler: clock50, MR, run, cs[2:0] inputs; tick output. It contains the free-running prescaler counter and the tick decode.
- timer0_ctrl holds the FSM, the registers, the compare/overflow logic and the register bus.

Test Plan:
- Reset mid-count: Normal mode, CS=001, TCNT at 0x37, assert MR asynchronously -> tcnt=0, TIFR=0, oc0=0 with no clock edge; counting resumes only after a new TCCR0 write.
- Overflow: Normal mode, CS=010, TCNT=0xFE, TOIE0=1 -> TCNT=0xFF after 8 clocks and 0x00 after 16 clocks; TOV0 and irq_ovf=1 from the next clock; writing TIFR=0x01 clears both.
- CTC: CS=001, OCR=4, COM0=01 -> TCNT sequence 0,1,2,3,4,0; OCF0 set on each return to 0; oc0 toggles every 5 clocks; TOV0 never set.
- TCNT write and compare block: CS=001, OCR=0x10, write TCNT=0x10 -> no OCF0 on the next tick (TCNT becomes 0x11); OCF0 set at the following 0x10 after wrap.
- Simultaneous events:
  - TIFR clear in the same cycle as an OCF0 set -> OCF0 stays 1.
  - TCNT write of 0x80 on a tick edge -> tcnt=0x80 with no increment.
- Stop and FOC0: CS=110 -> tcnt frozen and prescaler 0. FOC0 write with COM0=11 -> oc0=1, OCF0 remains 0.

Source files
------------

// File: rtl/timer0_pkg.sv
// Shared definitions for the Timer/Counter0 controller: register map,
// TCCR0/TIFR/TIMSK field positions, clock-select and compare-output
// encodings, FSM states and two small decode helpers.
package timer0_pkg;

  // Register bus addresses; 5-7 are reserved and read as zero
  localparam logic [2:0] ADDR_TCCR0 = 3'd0;
  localparam logic [2:0] ADDR_TCNT0 = 3'd1;
  localparam logic [2:0] ADDR_OCR0  = 3'd2;
  localparam logic [2:0] ADDR_TIFR  = 3'd3;
  localparam logic [2:0] ADDR_TIMSK = 3'd4;

  // TCCR0 field positions
  localparam int TCCR_FOC0    = 7;
  localparam int TCCR_COM0_HI = 5;
  localparam int TCCR_COM0_LO = 4;
  localparam int TCCR_CTC     = 3;
  localparam int TCCR_CS_HI   = 2;
  localparam int TCCR_CS_LO   = 0;

  // TIFR / TIMSK bit positions
  localparam int TIFR_OCF0   = 1;
  localparam int TIFR_TOV0   = 0;
  localparam int TIMSK_OCIE0 = 1;
  localparam int TIMSK_TOIE0 = 0;

  // Clock select; the two external-clock codes are not supported and stop the timer
  typedef enum logic [2:0] {
    CS_STOP     = 3'b000,
    CS_DIV1     = 3'b001,
    CS_DIV8     = 3'b010,
    CS_DIV64    = 3'b011,
    CS_DIV256   = 3'b100,
    CS_DIV1024  = 3'b101,
    CS_EXT_FALL = 3'b110,
    CS_EXT_RISE = 3'b111
  } cs_e;

  // Compare output mode applied to oc0 on a match or a forced compare
  typedef enum logic [1:0] {
    COM_DISC   = 2'b00,
    COM_TOGGLE = 2'b01,
    COM_CLEAR  = 2'b10,
    COM_SET    = 2'b11
  } com_e;

  // Controller state
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // True when a clock-select code produces count ticks
  function automatic logic csRuns(input logic [2:0] cs);
    logic runs;
    runs = 1'b0;
    case (cs)
      CS_DIV1, CS_DIV8, CS_DIV64, CS_DIV256, CS_DIV1024: runs = 1'b1;
      default:                                           runs = 1'b0;
    endcase
    return runs;
  endfunction

  // New oc0 level after applying a compare output action to the current level
  function automatic logic comApply(input logic [1:0] com, input logic cur);
    logic nxt;
    nxt = cur;
    case (com)
      COM_TOGGLE: nxt = ~cur;
      COM_CLEAR:  nxt = 1'b0;
      COM_SET:    nxt = 1'b1;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler for Timer/Counter0. Counts every clock while the
// timer runs, sits at zero while stopped, and decodes the selected
// division into a single-cycle count tick.
module timer_prescaler
  import timer0_pkg::*;
#(
  parameter int PRESC_WIDTH = 10
) (
  input  logic       clock50,
  input  logic       MR,
  input  logic       run,
  input  logic [2:0] cs,
  output logic       tick
);

  logic [PRESC_WIDTH-1:0] presc_q;
  logic [PRESC_WIDTH-1:0] presc_d;

  // Advance while running, park at zero while stopped so a restart begins a full period
  always_comb begin
    presc_d = '0;
    if (run) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Prescaler register
  always_ff @(posedge clock50 or posedge MR) begin
    if (MR) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // A /N tick fires when the low log2(N) bits are all ones, i.e. on the Nth clock
  always_comb begin
    tick = 1'b0;
    if (run) begin
      case (cs)
        CS_DIV1:    tick = 1'b1;
        CS_DIV8:    tick = &presc_q[2:0];
        CS_DIV64:   tick = &presc_q[5:0];
        CS_DIV256:  tick = &presc_q[7:0];
        CS_DIV1024: tick = &presc_q[9:0];
        default:    tick = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/timer0_ctrl.sv
// Timer/Counter0 controller for the ATMega32A emulator. Holds TCCR0, TCNT0,
// OCR0, TIFR and TIMSK, runs Normal and CTC count modes off the prescaler
// tick, raises overflow/compare flags and interrupts, and drives oc0.
module timer0_ctrl
  import timer0_pkg::*;
#(
  parameter int PRESC_WIDTH = 10,
  parameter int TCNT_WIDTH  = 8
) (
  input  logic                  clock50,
  input  logic                  MR,
  input  logic                  wr_en,
  input  logic [2:0]            addr,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic [TCNT_WIDTH-1:0] tcnt,
  output logic                  irq_ovf,
  output logic                  irq_cmp,
  output logic                  oc0
);

  localparam logic [TCNT_WIDTH-1:0] TCNT_MAX = '1;

  state_e                  state_q, state_d;
  logic [6:0]              tccr_q, tccr_d;
  logic [TCNT_WIDTH-1:0]   tcnt_q, tcnt_d;
  logic [7:0]              ocr_q, ocr_d;
  logic                    ocf_q, ocf_d;
  logic                    tov_q, tov_d;
  logic                    ocie_q, ocie_d;
  logic                    toie_q, toie_d;
  logic                    oc0_q, oc0_d;
  logic                    cmpBlock_q, cmpBlock_d;

  logic       tccrWrite, tcntWrite, ocrWrite, tifrWrite, timskWrite;
  logic       forceCmp;
  logic [2:0] csNext;
  logic       running;
  logic       tick;
  logic       tickEff;
  logic       match;
  logic       ocfSet;
  logic       tovSet;
  logic       ctcMode;
  logic [1:0] comMode;

  assign tccrWrite  = wr_en && (addr == ADDR_TCCR0);
  assign tcntWrite  = wr_en && (addr == ADDR_TCNT0);
  assign ocrWrite   = wr_en && (addr == ADDR_OCR0);
  assign tifrWrite  = wr_en && (addr == ADDR_TIFR);
  assign timskWrite = wr_en && (addr == ADDR_TIMSK);
  assign forceCmp   = tccrWrite && wr_data[TCCR_FOC0];

  assign ctcMode = tccr_q[TCCR_CTC];
  assign comMode = tccr_q[TCCR_COM0_HI:TCCR_COM0_LO];
  assign csNext  = tccrWrite ? wr_data[TCCR_CS_HI:TCCR_CS_LO] : tccr_q[TCCR_CS_HI:TCCR_CS_LO];
  assign running = (state_q == ST_RUN);

  // A TCNT write in the same cycle as a tick takes precedence and swallows the tick
  assign tickEff = tick && !tcntWrite;
  assign match   = (tcnt_q == ocr_q) && !cmpBlock_q;

  timer_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) uPrescaler (
    .clock50 (clock50),
    .MR      (MR),
    .run     (running),
    .cs      (tccr_q[TCCR_CS_HI:TCCR_CS_LO]),
    .tick    (tick)
  );

  // Start on a write of a valid clock select, stop as soon as the effective select means stop
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (tccrWrite && csRuns(wr_data[TCCR_CS_HI:TCCR_CS_LO])) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!csRuns(csNext)) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  // FSM state register
  always_ff @(posedge clock50 or posedge MR) begin
    if (MR) begin
      state_q <= ST_STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // Counter update: match reloads in CTC, otherwise increment; a TCNT write overrides and arms the compare block
  always_comb begin
    tcnt_d     = tcnt_q;
    cmpBlock_d = cmpBlock_q;
    ocfSet     = 1'b0;
    tovSet     = 1'b0;
    if (tickEff) begin
      cmpBlock_d = 1'b0;
      tovSet     = (tcnt_q == TCNT_MAX);
      if (match) begin
        ocfSet = 1'b1;
        tcnt_d = ctcMode ? '0 : tcnt_q + 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
    if (tcntWrite) begin
      tcnt_d     = wr_data;
      cmpBlock_d = 1'b1;
    end
  end

  // Flags clear on a written one, but a hardware set in the same cycle wins
  always_comb begin
    ocf_d = (ocf_q && !(tifrWrite && wr_data[TIFR_OCF0])) || ocfSet;
    tov_d = (tov_q && !(tifrWrite && wr_data[TIFR_TOV0])) || tovSet;
  end

  // Compare output: a forced compare uses the COM0 being written and overrides a same-cycle match
  always_comb begin
    oc0_d = oc0_q;
    if (forceCmp) begin
      oc0_d = comApply(wr_data[TCCR_COM0_HI:TCCR_COM0_LO], oc0_q);
    end else if (tickEff && match) begin
      oc0_d = comApply(comMode, oc0_q);
    end
  end

  // Plain bus-written configuration registers; FOC0 is a strobe and is not stored
  always_comb begin
    tccr_d = tccr_q;
    ocr_d  = ocr_q;
    ocie_d = ocie_q;
    toie_d = toie_q;
    if (tccrWrite) begin
      tccr_d = wr_data[6:0];
    end
    if (ocrWrite) begin
      ocr_d = wr_data;
    end
    if (timskWrite) begin
      ocie_d = wr_data[TIMSK_OCIE0];
      toie_d = wr_data[TIMSK_TOIE0];
    end
  end

  // Datapath and register-file storage
  always_ff @(posedge clock50 or posedge MR) begin
    if (MR) begin
      tccr_q     <= '0;
      tcnt_q     <= '0;
      ocr_q      <= '0;
      ocf_q      <= 1'b0;
      tov_q      <= 1'b0;
      ocie_q     <= 1'b0;
      toie_q     <= 1'b0;
      oc0_q      <= 1'b0;
      cmpBlock_q <= 1'b0;
    end else begin
      tccr_q     <= tccr_d;
      tcnt_q     <= tcnt_d;
      ocr_q      <= ocr_d;
      ocf_q      <= ocf_d;
      tov_q      <= tov_d;
      ocie_q     <= ocie_d;
      toie_q     <= toie_d;
      oc0_q      <= oc0_d;
      cmpBlock_q <= cmpBlock_d;
    end
  end

  // Zero-latency register read; reserved addresses and unused bits read as zero
  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_TCCR0: rd_data = {1'b0, tccr_q};
      ADDR_TCNT0: rd_data = tcnt_q;
      ADDR_OCR0:  rd_data = ocr_q;
      ADDR_TIFR:  rd_data = {6'b0, ocf_q, tov_q};
      ADDR_TIMSK: rd_data = {6'b0, ocie_q, toie_q};
      default:    rd_data = 8'h00;
    endcase
  end

  assign tcnt    = tcnt_q;
  assign irq_ovf = tov_q && toie_q;
  assign irq_cmp = ocf_q && ocie_q;
  assign oc0     = oc0_q;

endmodule

// File: tb/tb_timer0_ctrl.sv
// Scoreboard bench for timer0_ctrl. The driver applies one bus cycle per
// clock, predicts what the DUT should show during that cycle from an
// integer reference model of Timer/Counter0, and queues the prediction;
// a monitor pops and compares on every falling edge.
module tb_timer0_ctrl;

  localparam int A_TCCR  = 0;
  localparam int A_TCNT  = 1;
  localparam int A_OCR   = 2;
  localparam int A_TIFR  = 3;
  localparam int A_TIMSK = 4;

  logic       clock50;
  logic       MR;
  logic       wr_en;
  logic [2:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic [7:0] tcnt;
  logic       irq_ovf;
  logic       irq_cmp;
  logic       oc0;

  typedef struct {
    int tcnt;
    int ocr;
    int tccr;
    bit tov;
    bit ocf;
    bit toie;
    bit ocie;
    bit oc0;
    bit blk;
    bit running;
    int presc;
  } model_t;

  typedef struct {
    int cycle;
    int tcnt;
    int irqOvf;
    int irqCmp;
    int oc0;
    int rd;
  } exp_t;

  exp_t   expQ[$];
  model_t mdl;
  int     checks;
  int     errors;
  int     cycleNo;

  timer0_ctrl #(
    .PRESC_WIDTH (10),
    .TCNT_WIDTH  (8)
  ) dut (
    .clock50 (clock50),
    .MR      (MR),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .tcnt    (tcnt),
    .irq_ovf (irq_ovf),
    .irq_cmp (irq_cmp),
    .oc0     (oc0)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  // Division ratio for a clock-select code, 0 meaning the timer is stopped
  function automatic int divisor(input int cs);
    case (cs)
      1:       return 1;
      2:       return 8;
      3:       return 64;
      4:       return 256;
      5:       return 1024;
      default: return 0;
    endcase
  endfunction

  function automatic bit comLevel(input int com, input bit cur);
    case (com)
      1:       return !cur;
      2:       return 1'b0;
      3:       return 1'b1;
      default: return cur;
    endcase
  endfunction

  function automatic model_t resetModel();
    model_t r;
    r.tcnt = 0; r.ocr = 0; r.tccr = 0;
    r.tov = 0; r.ocf = 0; r.toie = 0; r.ocie = 0; r.oc0 = 0;
    r.blk = 0; r.running = 0; r.presc = 0;
    return r;
  endfunction

  function automatic int readModel(input model_t m, input int a);
    case (a)
      A_TCCR:  return m.tccr;
      A_TCNT:  return m.tcnt;
      A_OCR:   return m.ocr;
      A_TIFR:  return 2 * int'(m.ocf) + int'(m.tov);
      A_TIMSK: return 2 * int'(m.ocie) + int'(m.toie);
      default: return 0;
    endcase
  endfunction

  // One rising edge of Timer/Counter0 behaviour, from the datasheet-style rules
  function automatic model_t nextModel(input model_t c, input bit we, input int a, input int d);
    model_t n = c;
    int  div     = divisor(c.tccr % 8);
    bit  tickNow = c.running && (div != 0) && ((c.presc % div) == div - 1);
    bit  tcntW   = we && (a == A_TCNT);
    bit  matched = 0;
    int  csAfter;
    if (we && a == A_TIFR) begin
      if ((d & 2) != 0) n.ocf = 0;
      if ((d & 1) != 0) n.tov = 0;
    end
    if (tickNow && !tcntW) begin
      n.blk = 0;
      if (c.tcnt == 255) n.tov = 1;
      if (c.tcnt == c.ocr && !c.blk) begin
        matched = 1;
        n.ocf   = 1;
        n.oc0   = comLevel((c.tccr / 16) % 4, c.oc0);
        n.tcnt  = ((c.tccr & 8) != 0) ? 0 : (c.tcnt + 1) % 256;
      end else begin
        n.tcnt = (c.tcnt + 1) % 256;
      end
    end
    if (tcntW) begin
      n.tcnt = d;
      n.blk  = 1;
    end
    if (we && a == A_OCR) n.ocr = d;
    if (we && a == A_TIMSK) begin
      n.ocie = (d & 2) != 0;
      n.toie = (d & 1) != 0;
    end
    if (we && a == A_TCCR) begin
      n.tccr = d % 128;
      if (d >= 128) n.oc0 = comLevel((d / 16) % 4, c.oc0);
    end
    n.presc = c.running ? c.presc + 1 : 0;
    csAfter   = (we && a == A_TCCR) ? d % 8 : c.tccr % 8;
    n.running = divisor(csAfter) != 0;
    return n;
  endfunction

  // Drive one bus cycle, queue what the DUT must show during it, then advance the model
  task automatic applyStimulus(input bit mr, input bit we, input int a, input int d);
    exp_t e;
    @(posedge clock50);
    #2;
    MR      = mr;
    wr_en   = we;
    addr    = a[2:0];
    wr_data = d[7:0];
    if (mr) mdl = resetModel();
    e.cycle  = cycleNo;
    e.tcnt   = mdl.tcnt;
    e.irqOvf = int'(mdl.tov && mdl.toie);
    e.irqCmp = int'(mdl.ocf && mdl.ocie);
    e.oc0    = int'(mdl.oc0);
    e.rd     = readModel(mdl, a);
    expQ.push_back(e);
    if (!mr) mdl = nextModel(mdl, we, a, d);
    cycleNo++;
  endtask

  task automatic wr(input int a, input int d);
    applyStimulus(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, $urandom_range(0, 7), 0);
  endtask

  task automatic pulseReset();
    applyStimulus(1'b1, 1'b0, $urandom_range(0, 7), 0);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected, input int cyc);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // Monitor: every falling edge compare the DUT against the oldest queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clock50);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("tcnt",    int'(tcnt),    e.tcnt,   e.cycle);
        checkOutput("irq_ovf", int'(irq_ovf), e.irqOvf, e.cycle);
        checkOutput("irq_cmp", int'(irq_cmp), e.irqCmp, e.cycle);
        checkOutput("oc0",     int'(oc0),     e.oc0,    e.cycle);
        checkOutput("rd_data", int'(rd_data), e.rd,     e.cycle);
      end
    end
  end

  // Directed scenarios followed by a randomized run
  initial begin
    int r;
    int a;
    int d;
    checks  = 0;
    errors  = 0;
    cycleNo = 0;
    MR      = 1'b1;
    wr_en   = 1'b0;
    addr    = 3'd0;
    wr_data = 8'h00;
    mdl     = resetModel();

    $display("[TB] reset state");
    pulseReset();
    pulseReset();
    idle(3);

    $display("[TB] asynchronous reset mid-count");
    wr(A_TIFR, 0);
    wr(A_TCCR, 8'h01);
    wr(A_TCNT, 8'h30);
    idle(7);
    pulseReset();
    idle(6);

    $display("[TB] overflow with /8");
    wr(A_TIMSK, 8'h01);
    wr(A_OCR, 8'h80);
    wr(A_TCNT, 8'hFE);
    wr(A_TCCR, 8'h02);
    idle(20);
    wr(A_TIFR, 8'h01);
    idle(4);

    $display("[TB] CTC toggle, OCR=4");
    pulseReset();
    wr(A_TIMSK, 8'h03);
    wr(A_OCR, 8'h04);
    wr(A_TCCR, 8'h19);
    idle(24);

    $display("[TB] CTC with OCR=0 and OCR=0xFF");
    wr(A_OCR, 8'h00);
    idle(4);
    wr(A_OCR, 8'hFF);
    idle(260);

    $display("[TB] TCNT write arms the compare block");
    pulseReset();
    wr(A_TIMSK, 8'h02);
    wr(A_OCR, 8'h10);
    wr(A_TCCR, 8'h21);
    wr(A_TCNT, 8'h10);
    idle(262);

    $display("[TB] simultaneous flag clear and set, TCNT write on tick");
    pulseReset();
    wr(A_TIMSK, 8'h02);
    wr(A_OCR, 8'h02);
    wr(A_TCCR, 8'h09);
    for (int i = 0; i < 6; i++) wr(A_TIFR, 8'h02);
    wr(A_TCCR, 8'h01);
    wr(A_TCNT, 8'h80);
    idle(3);

    $display("[TB] external clock select stops, FOC0 forces oc0");
    wr(A_TCCR, 8'h06);
    idle(10);
    wr(A_TCCR, 8'h30);
    wr(A_TCCR, 8'hB0);
    idle(2);
    wr(A_TCCR, 8'h90);
    idle(2);
    wr(A_TCCR, 8'hA2);
    idle(12);

    $display("[TB] randomized traffic");
    pulseReset();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) begin
        pulseReset();
      end else if (r < 300) begin
        a = $urandom_range(0, 7);
        d = $urandom_range(0, 255);
        if (a == A_TCCR) d = (d & 8'hF8) | (($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2));
        if (a == A_TCNT && $urandom_range(0, 2) == 0) d = $urandom_range(250, 255);
        if (a == A_OCR && $urandom_range(0, 1) == 0) d = $urandom_range(0, 12);
        wr(a, d);
      end else begin
        idle(1);
      end
    end

    idle(2);
    repeat (3) @(negedge clock50);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d predictions pending, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
